// File: rtl/gtstamp.sv
// -----------------------------------------------------------------------------
// gtstamp -- trigger time-stamp capture with a 4-deep readout FIFO
//
// On each rising edge of trig the block waits SETTLE+1 adcclk cycles and then
// latches the 25-bit time stamp gtout ({22-bit counter, 3-bit phase}) into a
// 4-entry FIFO. Stored stamps are read out oldest-first as two 16-bit words:
//   W0 = {3'b101, P, 3'b000, ts[24:16]}
//   W1 = ts[15:0]
//
// Parameters
//   SETTLE     adcclk cycles from trigger edge to gtout sample (1..15)
//
// Ports
//   adcclk     ADC clock; every register is clocked on its rising edge
//   reset_n    synchronous active-low reset
//   trig       trigger input, synchronous to adcclk
//   gtout      time stamp to capture, stable SETTLE cycles after trig rises
//   clr        clears the sticky ovf / lost flags
//   dout       readout word (W0 or W1 of the oldest stamp)
//   dvalid     dout holds a valid word (at least one stamp stored)
//   drd        consumer accepts dout this cycle
//   nstamp     number of stored stamps, 0..4
//   ovf        sticky: a stamp was dropped because the FIFO was full
//   lost       sticky: a trigger was ignored because a capture was busy
//
// Configuration
//   GTSTAMP_PARITY_EN  when defined, P = ^ts (even parity over W0 and W1);
//                      otherwise P = 0 and no parity logic is built.
// -----------------------------------------------------------------------------
module gtstamp #(
  parameter int unsigned SETTLE = 4
) (
  input  logic        adcclk,
  input  logic        reset_n,
  input  logic        trig,
  input  logic [24:0] gtout,
  input  logic        clr,
  output logic [15:0] dout,
  output logic        dvalid,
  input  logic        drd,
  output logic [2:0]  nstamp,
  output logic        ovf,
  output logic        lost
);

  localparam logic [3:0] C_SETTLE = 4'(SETTLE);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_SETTLE = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Trigger edge detection
  // ---------------------------------------------------------------------------
  logic   r_trig;
  // r_arm is low only while trig has stayed high since reset, so a trigger
  // that is already asserted when reset releases does not count as an edge.
  logic   r_arm;
  logic   w_edge;

  assign w_edge = trig & ~r_trig & r_arm;

  // ---------------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------------
  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       w_push;
  logic       w_busy_edge;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of block ordering.
  always_ff @(posedge adcclk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_trig  <= 1'b0;
      r_arm   <= ~trig;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_trig  <= trig;
      r_arm   <= r_arm | ~trig;
    end
  end

  // NOTE: every output of this block is given a default first so that no
  // path through the case statement leaves a signal unassigned (no latches).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_push      = 1'b0;
    w_busy_edge = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_edge) begin
          w_state_nxt = S_SETTLE;
          w_cnt_nxt   = C_SETTLE;
        end
      end
      S_SETTLE: begin
        // A new edge here is dropped; the running capture carries on.
        w_busy_edge = w_edge;
        if (r_cnt == 4'd0) begin
          w_push      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO and readout
  // ---------------------------------------------------------------------------
  logic [24:0] r_mem [4];
  logic [1:0]  r_wptr;
  logic [1:0]  r_rptr;
  logic [2:0]  r_count;
  logic        r_word;
  logic        r_ovf;
  logic        r_lost;

  logic        w_full;
  logic        w_wr;
  logic        w_xfer;
  logic        w_pop;
  logic        w_ovf_set;
  logic [24:0] w_ts;
  logic        w_par;

  // Fullness is judged on the stored count alone: a pop in the same cycle
  // does not make room for the incoming stamp.
  assign w_full    = (r_count == 3'd4);
  assign w_wr      = w_push & ~w_full;
  assign w_ovf_set = w_push & w_full;
  assign w_xfer    = dvalid & drd;
  assign w_pop     = w_xfer & r_word;

  // NOTE: the storage array has no reset; the pointers and count define which
  // entries are meaningful, and dout is don't-care while dvalid is low.
  always_ff @(posedge adcclk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= gtout;
    end
  end

  always_ff @(posedge adcclk) begin
    if (!reset_n) begin
      r_wptr  <= 2'd0;
      r_rptr  <= 2'd0;
      r_count <= 3'd0;
      r_word  <= 1'b0;
      r_ovf   <= 1'b0;
      r_lost  <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + 2'd1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 2'd1;
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
      if (w_xfer) begin
        r_word <= ~r_word;
      end
      // Set has priority over clear on the sticky flags.
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (clr) begin
        r_ovf <= 1'b0;
      end
      if (w_busy_edge) begin
        r_lost <= 1'b1;
      end else if (clr) begin
        r_lost <= 1'b0;
      end
    end
  end

  assign w_ts = r_mem[r_rptr];

`ifdef GTSTAMP_PARITY_EN
  assign w_par = ^w_ts;
`else
  assign w_par = 1'b0;
`endif

  assign dout   = r_word ? w_ts[15:0] : {3'b101, w_par, 3'b000, w_ts[24:16]};
  assign dvalid = (r_count != 3'd0);
  assign nstamp = r_count;
  assign ovf    = r_ovf;
  assign lost   = r_lost;

endmodule

// File: tb/tb_gtstamp.sv
// -----------------------------------------------------------------------------
// tb_gtstamp -- directed self-checking bench for gtstamp (SETTLE = 4)
// -----------------------------------------------------------------------------
module tb_gtstamp;

  logic        adcclk;
  logic        reset_n;
  logic        trig;
  logic [24:0] gtout;
  logic        clr;
  logic [15:0] dout;
  logic        dvalid;
  logic        drd;
  logic [2:0]  nstamp;
  logic        ovf;
  logic        lost;

  int checks   = 0;
  int failures = 0;

  gtstamp #(.SETTLE(4)) dut (
    .adcclk  (adcclk),
    .reset_n (reset_n),
    .trig    (trig),
    .gtout   (gtout),
    .clr     (clr),
    .dout    (dout),
    .dvalid  (dvalid),
    .drd     (drd),
    .nstamp  (nstamp),
    .ovf     (ovf),
    .lost    (lost)
  );

  initial adcclk = 1'b0;
  always #5 adcclk = ~adcclk;

  task automatic tick();
    @(posedge adcclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] f_w0(input logic [24:0] ts);
    logic p;
    p = 1'b0;
`ifdef GTSTAMP_PARITY_EN
    p = ^ts;
`endif
    return {3'b101, p, 3'b000, ts[24:16]};
  endfunction

  function automatic logic [15:0] f_w1(input logic [24:0] ts);
    return ts[15:0];
  endfunction

  logic [24:0] s_c [5];
  logic [24:0] s_d [4];
  logic [15:0] exp_q [$];
  int          exp_cnt;
  logic        exp_word;

  initial begin
    s_c = '{25'h0000111, 25'h1000222, 25'h0ABC333, 25'h1FFF444, 25'h0555555};
    s_d = '{25'h0246801, 25'h1357902, 25'h00F00F3, 25'h1DEAD04};

    reset_n = 1'b0;
    trig    = 1'b0;
    gtout   = '0;
    clr     = 1'b0;
    drd     = 1'b0;

    // ---------------- reset state ----------------
    tick();
    tick();
    reset_n = 1'b1;
    check("rst_nstamp", 32'(nstamp), 32'd0);
    check("rst_dvalid", 32'(dvalid), 32'd0);
    check("rst_ovf",    32'(ovf),    32'd0);
    check("rst_lost",   32'(lost),   32'd0);

    // ---------------- single stamp, latency and word format ----------------
    gtout = 25'h1ABCDEF;
    drd   = 1'b1;
    trig  = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("a_dvalid_low_%0d", i), 32'(dvalid), 32'd0);
    end
    tick();
    check("a_dvalid_high", 32'(dvalid), 32'd1);
    check("a_nstamp1",     32'(nstamp), 32'd1);
    check("a_w0",          32'(dout),   32'h0000A1AB);
    tick();
    check("a_w1",          32'(dout),   32'h0000CDEF);
    check("a_nstamp_w1",   32'(nstamp), 32'd1);
    tick();
    check("a_empty_dv",    32'(dvalid), 32'd0);
    check("a_empty_ns",    32'(nstamp), 32'd0);
    // trig still held high: no second edge
    repeat (8) tick();
    check("a_held_ns",     32'(nstamp), 32'd0);
    check("a_held_lost",   32'(lost),   32'd0);
    trig = 1'b0;
    drd  = 1'b0;
    tick();

    // ---------------- edge during capture -> lost ----------------
    gtout = 25'h0123456;
    trig  = 1'b1;
    tick();
    trig = 1'b0;
    tick();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    check("b_lost_set",  32'(lost),   32'd1);
    check("b_ns_before", 32'(nstamp), 32'd0);
    repeat (3) tick();
    check("b_ns_push",   32'(nstamp), 32'd1);
    repeat (6) tick();
    check("b_ns_one",    32'(nstamp), 32'd1);
    check("b_lost_hold", 32'(lost),   32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("b_lost_clr",  32'(lost),   32'd0);
    drd = 1'b1;
    check("b_w0", 32'(dout), 32'(f_w0(25'h0123456)));
    tick();
    check("b_w1", 32'(dout), 32'(f_w1(25'h0123456)));
    tick();
    drd = 1'b0;
    check("b_empty", 32'(dvalid), 32'd0);

    // ---------------- five edges, FIFO overflow ----------------
    for (int i = 0; i < 5; i++) begin
      gtout = s_c[i];
      trig  = 1'b1;
      tick();
      trig = 1'b0;
      repeat (9) tick();
      if (i == 3) begin
        check("c_ns_full",    32'(nstamp), 32'd4);
        check("c_ovf_before", 32'(ovf),    32'd0);
      end
    end
    check("c_ns_after",  32'(nstamp), 32'd4);
    check("c_ovf_set",   32'(ovf),    32'd1);

    // dropped push in the same cycle as clr: set wins
    gtout = 25'h1234567;
    trig  = 1'b1;
    tick();
    trig = 1'b0;
    repeat (4) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("c_ovf_setwins", 32'(ovf),    32'd1);
    check("c_ns_still4",   32'(nstamp), 32'd4);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("c_ovf_clr",     32'(ovf),    32'd0);

    drd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("c_rd_ns_%0d", i), 32'(nstamp), 32'(4 - i));
      check($sformatf("c_rd_w0_%0d", i), 32'(dout),   32'(f_w0(s_c[i])));
      tick();
      check($sformatf("c_rd_w1_%0d", i), 32'(dout),   32'(f_w1(s_c[i])));
      tick();
    end
    drd = 1'b0;
    check("c_rd_empty_dv", 32'(dvalid), 32'd0);
    check("c_rd_empty_ns", 32'(nstamp), 32'd0);

    // ---------------- toggling drd with a concurrent push ----------------
    for (int k = 0; k < 3; k++) begin
      gtout = s_d[k];
      trig  = 1'b1;
      tick();
      trig = 1'b0;
      repeat (6) tick();
    end
    check("d_preload_ns", 32'(nstamp), 32'd3);
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(f_w0(s_d[k]));
      exp_q.push_back(f_w1(s_d[k]));
    end
    exp_cnt  = 3;
    exp_word = 1'b0;
    gtout    = s_d[3];
    for (int c = 0; c < 20; c++) begin
      drd  = (c % 2 == 0);
      trig = (c == 1);
      check($sformatf("d_ns_c%0d", c), 32'(nstamp), 32'(exp_cnt));
      check($sformatf("d_dv_c%0d", c), 32'(dvalid), 32'(exp_cnt != 0));
      if (exp_cnt != 0) begin
        check($sformatf("d_dout_c%0d", c), 32'(dout), 32'(exp_q[0]));
      end
      if (drd && exp_cnt != 0) begin
        void'(exp_q.pop_front());
        if (exp_word) exp_cnt--;
        exp_word = ~exp_word;
      end
      if (c == 6) begin
        exp_cnt++;
        exp_q.push_back(f_w0(s_d[3]));
        exp_q.push_back(f_w1(s_d[3]));
      end
      tick();
    end
    drd  = 1'b0;
    trig = 1'b0;
    check("d_end_dv",   32'(dvalid), 32'd0);
    check("d_end_lost", 32'(lost),   32'd0);

    // ---------------- reset mid-capture and mid-readout ----------------
    trig = 1'b1;
    tick();
    trig = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (8) tick();
    check("e_nopush_ns", 32'(nstamp), 32'd0);
    check("e_nopush_dv", 32'(dvalid), 32'd0);

    gtout = 25'h0F0F0F0;
    trig  = 1'b1;
    tick();
    trig = 1'b0;
    repeat (5) tick();
    check("e_one_ns", 32'(nstamp), 32'd1);
    drd = 1'b1;
    tick();
    drd = 1'b0;
    check("e_mid_w1", 32'(dout),   32'(f_w1(25'h0F0F0F0)));
    check("e_mid_ns", 32'(nstamp), 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("e_rst_ns", 32'(nstamp), 32'd0);
    check("e_rst_dv", 32'(dvalid), 32'd0);
    tick();
    check("e_rst_ns2", 32'(nstamp), 32'd0);

    gtout = 25'h1333ACE;
    trig  = 1'b1;
    tick();
    trig = 1'b0;
    repeat (5) tick();
    check("e_new_ns", 32'(nstamp), 32'd1);
    check("e_new_w0", 32'(dout),   32'(f_w0(25'h1333ACE)));
    drd = 1'b1;
    tick();
    tick();
    drd = 1'b0;
    check("e_drain_dv", 32'(dvalid), 32'd0);

    // ---------------- reset released with trig high ----------------
    reset_n = 1'b0;
    trig    = 1'b1;
    tick();
    reset_n = 1'b1;
    repeat (8) tick();
    check("f_noedge_ns", 32'(nstamp), 32'd0);
    gtout = 25'h0000ACE;
    trig  = 1'b0;
    tick();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    repeat (5) tick();
    check("f_edge_ns",  32'(nstamp), 32'd1);
    check("f_edge_w0",  32'(dout),   32'(f_w0(25'h0000ACE)));
    check("f_lost",     32'(lost),   32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
